// File: rtl/wisc_pkg.sv
// Shared IF/ID definitions: instruction width, NOP encoding, HALT opcode
// and the record carried by each fetch skid entry.
package wisc_pkg;

  localparam int INSTR_W = 16;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0800;
  localparam logic [4:0] OPC_HALT = 5'b00000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [INSTR_W-1:0] pc_inc;
    logic               err;
  } fetch_entry_t;

  // HALT is recognised purely by the top five opcode bits.
  function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1:INSTR_W-5] == OPC_HALT;
  endfunction

endpackage

// File: rtl/if_id_skid_reg_skid_fifo.sv
// skid_fifo: shift-register FIFO of fetch entries. Entry 0 is the head.
// A pop shifts every entry one slot towards the head; a push writes the
// first free slot after that shift, so push+pop keeps count unchanged.
module skid_fifo
  import wisc_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_clear,
  input  fetch_entry_t     i_data,
  output fetch_entry_t     o_head,
  output logic [CNT_W-1:0] o_count
);

  fetch_entry_t [DEPTH-1:0] r_ent;
  fetch_entry_t [DEPTH-1:0] w_next;
  logic [CNT_W-1:0]         r_count;
  logic [CNT_W-1:0]         w_count_nxt;
  logic [CNT_W-1:0]         w_widx;

  // Next-state of the entry array: shift on pop, then drop the new entry in.
  always_comb begin
    w_next = r_ent;
    w_widx = i_pop ? (r_count - CNT_W'(1)) : r_count;
    if (i_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        w_next[i] = r_ent[i+1];
      end
    end
    if (i_push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_widx == CNT_W'(i)) begin
          w_next[i] = i_data;
        end
      end
    end
    case ({i_push, i_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Entry and occupancy registers; clear empties the FIFO, stale data is invisible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ent   <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else begin
      r_ent   <= w_next;
      r_count <= w_count_nxt;
    end
  end

  assign o_head  = r_ent[0];
  assign o_count = r_count;

endmodule

// File: rtl/if_id_skid_reg.sv
// if_id_skid_reg: IF->ID boundary with a small skid FIFO, flush squash,
// HALT-gated fetch acceptance and NOP masking of the head.
// Optional feature: define IF_ID_PERF_CNT_EN to add the bubble_cnt output.
module if_id_skid_reg #(
  parameter int DEPTH   = 2,
  parameter int INSTR_W = wisc_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_valid,
  input  logic [INSTR_W-1:0] if_instr,
  input  logic [INSTR_W-1:0] if_pc_inc,
  input  logic               if_err,
  output logic               if_ready,
  input  logic               id_stall,
  input  logic               flush,
  output logic               IF_ID_valid,
  output logic [INSTR_W-1:0] IF_ID_instr,
  output logic [INSTR_W-1:0] IF_ID_pc_inc,
  output logic               IF_ID_err,
  output logic               IF_ID_halt
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [15:0]        bubble_cnt
`endif
);

  import wisc_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             r_halt_seen;
  logic [CNT_W-1:0] w_count;
  logic             w_valid;
  logic             w_ready;
  logic             w_push;
  logic             w_pop;
  fetch_entry_t     w_in;
  fetch_entry_t     w_head;

  // Handshake: ready uses registered state only, so it never depends on stall/flush.
  always_comb begin
    w_valid = (w_count != '0);
    w_ready = (w_count < CNT_W'(DEPTH)) && !r_halt_seen;
    w_push  = if_valid && w_ready && !flush;
    w_pop   = w_valid && !id_stall && !flush;
    w_in    = '{instr: if_instr, pc_inc: if_pc_inc, err: if_err};
  end

  skid_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (flush),
    .i_data  (w_in),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // Once a HALT is accepted, stop taking fetches until a flush squashes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_halt_seen <= 1'b0;
    end else if (flush) begin
      r_halt_seen <= 1'b0;
    end else if (w_push && is_halt(if_instr)) begin
      r_halt_seen <= 1'b1;
    end
  end

  // Decode-facing outputs: head contents when valid, otherwise a clean NOP.
  always_comb begin
    if_ready     = w_ready;
    IF_ID_valid  = w_valid;
    IF_ID_instr  = w_valid ? w_head.instr  : NOP_INSTR;
    IF_ID_pc_inc = w_valid ? w_head.pc_inc : '0;
    IF_ID_err    = w_valid && w_head.err;
    IF_ID_halt   = w_valid && is_halt(w_head.instr);
  end

`ifdef IF_ID_PERF_CNT_EN
  logic [15:0] r_bubble_cnt;

  // Count cycles where decode gets no useful work; saturates, survives flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bubble_cnt <= '0;
    end else if ((!w_valid || id_stall) && (r_bubble_cnt != 16'hFFFF)) begin
      r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end
  end

  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Bench for if_id_skid_reg (DEPTH=2): a directed vector table applied one
// clock per row, plus hand-written async-reset and bubble-counter sequences.
module tb_if_id_skid_reg;

  logic        clk;
  logic        rst;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc_inc;
  logic        if_err;
  logic        if_ready;
  logic        id_stall;
  logic        flush;
  logic        IF_ID_valid;
  logic [15:0] IF_ID_instr;
  logic [15:0] IF_ID_pc_inc;
  logic        IF_ID_err;
  logic        IF_ID_halt;
`ifdef IF_ID_PERF_CNT_EN
  logic [15:0] bubble_cnt;
  logic [15:0] c0;
`endif

  int n_tests;
  int n_fail;

  if_id_skid_reg #(.DEPTH(2), .INSTR_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_pc_inc    (if_pc_inc),
    .if_err       (if_err),
    .if_ready     (if_ready),
    .id_stall     (id_stall),
    .flush        (flush),
    .IF_ID_valid  (IF_ID_valid),
    .IF_ID_instr  (IF_ID_instr),
    .IF_ID_pc_inc (IF_ID_pc_inc),
    .IF_ID_err    (IF_ID_err),
    .IF_ID_halt   (IF_ID_halt)
`ifdef IF_ID_PERF_CNT_EN
    ,
    .bubble_cnt   (bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        iv;
    logic [15:0] instr;
    logic [15:0] pc;
    logic        err;
    logic        stall;
    logic        fl;
    logic        ev;
    logic [15:0] einstr;
    logic [15:0] epc;
    logic        eerr;
    logic        erdy;
    logic        ehalt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    if_valid  = 1'b0;
    if_instr  = '0;
    if_pc_inc = '0;
    if_err    = 1'b0;
    id_stall  = 1'b0;
    flush     = 1'b0;

    //            iv instr    pc       e  st fl   ev einstr   epc      ee rdy hlt
    vecs.push_back('{1'b1,16'hC123,16'h0002,1'b0,1'b0,1'b0, 1'b1,16'hC123,16'h0002,1'b0,1'b1,1'b0});
    vecs.push_back('{1'b1,16'h4567,16'h0004,1'b1,1'b0,1'b0, 1'b1,16'h4567,16'h0004,1'b1,1'b1,1'b0});
    vecs.push_back('{1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b0, 1'b0,16'h0800,16'h0000,1'b0,1'b1,1'b0});
    vecs.push_back('{1'b1,16'hA001,16'h0006,1'b0,1'b1,1'b0, 1'b1,16'hA001,16'h0006,1'b0,1'b1,1'b0});
    vecs.push_back('{1'b1,16'hA002,16'h0008,1'b1,1'b1,1'b0, 1'b1,16'hA001,16'h0006,1'b0,1'b0,1'b0});
    vecs.push_back('{1'b1,16'hA003,16'h000A,1'b0,1'b1,1'b0, 1'b1,16'hA001,16'h0006,1'b0,1'b0,1'b0});
    vecs.push_back('{1'b1,16'hA003,16'h000A,1'b0,1'b0,1'b0, 1'b1,16'hA002,16'h0008,1'b1,1'b1,1'b0});
    vecs.push_back('{1'b1,16'hA003,16'h000A,1'b0,1'b0,1'b0, 1'b1,16'hA003,16'h000A,1'b0,1'b1,1'b0});
    vecs.push_back('{1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b0, 1'b0,16'h0800,16'h0000,1'b0,1'b1,1'b0});
    vecs.push_back('{1'b1,16'hB001,16'h0010,1'b0,1'b1,1'b0, 1'b1,16'hB001,16'h0010,1'b0,1'b1,1'b0});
    vecs.push_back('{1'b1,16'hB002,16'h0012,1'b0,1'b1,1'b0, 1'b1,16'hB001,16'h0010,1'b0,1'b0,1'b0});
    vecs.push_back('{1'b1,16'hB003,16'h0014,1'b1,1'b1,1'b1, 1'b0,16'h0800,16'h0000,1'b0,1'b1,1'b0});
    vecs.push_back('{1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b0, 1'b0,16'h0800,16'h0000,1'b0,1'b1,1'b0});
    vecs.push_back('{1'b1,16'h0000,16'h0016,1'b0,1'b1,1'b0, 1'b1,16'h0000,16'h0016,1'b0,1'b0,1'b1});
    vecs.push_back('{1'b1,16'hC999,16'h0018,1'b0,1'b1,1'b0, 1'b1,16'h0000,16'h0016,1'b0,1'b0,1'b1});
    vecs.push_back('{1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b0, 1'b0,16'h0800,16'h0000,1'b0,1'b0,1'b0});
    vecs.push_back('{1'b1,16'hC999,16'h0018,1'b0,1'b0,1'b1, 1'b0,16'h0800,16'h0000,1'b0,1'b1,1'b0});
    vecs.push_back('{1'b1,16'hC999,16'h0018,1'b0,1'b0,1'b0, 1'b1,16'hC999,16'h0018,1'b0,1'b1,1'b0});
    vecs.push_back('{1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b0, 1'b0,16'h0800,16'h0000,1'b0,1'b1,1'b0});
    vecs.push_back('{1'b1,16'hD001,16'h001A,1'b1,1'b1,1'b0, 1'b1,16'hD001,16'h001A,1'b1,1'b1,1'b0});
    vecs.push_back('{1'b1,16'h07FF,16'h001C,1'b0,1'b1,1'b0, 1'b1,16'hD001,16'h001A,1'b1,1'b0,1'b0});
    vecs.push_back('{1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b0, 1'b1,16'h07FF,16'h001C,1'b0,1'b0,1'b1});
    vecs.push_back('{1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b0, 1'b0,16'h0800,16'h0000,1'b0,1'b0,1'b0});
    vecs.push_back('{1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b1, 1'b0,16'h0800,16'h0000,1'b0,1'b1,1'b0});

    // Reset values while rst is held
    repeat (2) step();
    chk("rst.valid", 16'(IF_ID_valid), 16'h0000);
    chk("rst.instr", IF_ID_instr, 16'h0800);
    chk("rst.pc_inc", IF_ID_pc_inc, 16'h0000);
    chk("rst.err", 16'(IF_ID_err), 16'h0000);
    chk("rst.ready", 16'(if_ready), 16'h0001);
    chk("rst.halt", 16'(IF_ID_halt), 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    // Directed vector table, one clock per row
    for (int i = 0; i < vecs.size(); i++) begin
      if_valid  = vecs[i].iv;
      if_instr  = vecs[i].instr;
      if_pc_inc = vecs[i].pc;
      if_err    = vecs[i].err;
      id_stall  = vecs[i].stall;
      flush     = vecs[i].fl;
      step();
      chk($sformatf("v%0d.valid", i), 16'(IF_ID_valid), 16'(vecs[i].ev));
      chk($sformatf("v%0d.instr", i), IF_ID_instr, vecs[i].einstr);
      chk($sformatf("v%0d.pc_inc", i), IF_ID_pc_inc, vecs[i].epc);
      chk($sformatf("v%0d.err", i), 16'(IF_ID_err), 16'(vecs[i].eerr));
      chk($sformatf("v%0d.ready", i), 16'(if_ready), 16'(vecs[i].erdy));
      chk($sformatf("v%0d.halt", i), 16'(IF_ID_halt), 16'(vecs[i].ehalt));
    end
    flush = 1'b0;

    // Async reset mid-cycle with two entries held
    if_valid  = 1'b1;
    if_instr  = 16'hE001;
    if_pc_inc = 16'h0020;
    if_err    = 1'b1;
    id_stall  = 1'b1;
    step();
    if_instr  = 16'hE002;
    if_pc_inc = 16'h0022;
    step();
    chk("ar.full_valid", 16'(IF_ID_valid), 16'h0001);
    chk("ar.full_ready", 16'(if_ready), 16'h0000);
    if_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("ar.valid", 16'(IF_ID_valid), 16'h0000);
    chk("ar.instr", IF_ID_instr, 16'h0800);
    chk("ar.pc_inc", IF_ID_pc_inc, 16'h0000);
    chk("ar.err", 16'(IF_ID_err), 16'h0000);
    chk("ar.ready", 16'(if_ready), 16'h0001);
    @(negedge clk);
    rst = 1'b0;
    id_stall = 1'b0;
    step();
    chk("ar.after_valid", 16'(IF_ID_valid), 16'h0000);
    chk("ar.after_instr", IF_ID_instr, 16'h0800);

`ifdef IF_ID_PERF_CNT_EN
    // Bubble counter: 5 stalled + 2 empty cycles, then flush must not clear it
    c0 = bubble_cnt;
    if_valid = 1'b0;
    id_stall = 1'b1;
    repeat (5) step();
    id_stall = 1'b0;
    repeat (2) step();
    chk("perf.seven", bubble_cnt, c0 + 16'd7);
    if_valid  = 1'b1;
    if_instr  = 16'hF001;
    if_pc_inc = 16'h0030;
    if_err    = 1'b0;
    step();
    chk("perf.head_valid", 16'(IF_ID_valid), 16'h0001);
    if_valid = 1'b0;
    flush    = 1'b1;
    step();
    flush = 1'b0;
    chk("perf.flush_keep", bubble_cnt, c0 + 16'd8);
    chk("perf.flush_empty", 16'(IF_ID_valid), 16'h0000);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
